// File: rtl/axis_packetizer_pkg.sv
// Shared types and widths for the AXIS packetizer and its output register slice.
package axis_packetizer_pkg;

  localparam int unsigned BEAT_IDX_W = 16;
  localparam int unsigned IDLE_CNT_W = 16;
  localparam int unsigned CNT_W      = 32;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StFill = 2'd1;
  localparam state_t StPad  = 2'd2;

endpackage

// File: rtl/axis_out_reg.sv
// Single-stage AXIS register slice (TDATA/TLAST/TVALID) with an external load enable.
// The caller loads a beat only when slot_free_o is high.
module axis_out_reg #(
  parameter int unsigned DataWidth = 512
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 load_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 last_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [DataWidth-1:0] data_o,
  output logic                 last_o,
  output logic                 slot_free_o
);

  logic                 valid_q, valid_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 last_q, last_d;

  assign slot_free_o = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/axis_packetizer.sv
// Groups a TLAST-less AXIS stream into fixed PACKET_BEATS packets, zero-padding after TIMEOUT
// idle cycles. Optional AXIS_PACKETIZER_PAD_COUNT_EN adds pad_count and padding outputs.
module axis_packetizer
  import axis_packetizer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 512,
  parameter int unsigned PACKET_BEATS = 64,
  parameter int unsigned TIMEOUT      = 128
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] AXIS_IN_TDATA,
  input  logic                  AXIS_IN_TVALID,
  output logic                  AXIS_IN_TREADY,
  output logic [DATA_WIDTH-1:0] AXIS_OUT_TDATA,
  output logic                  AXIS_OUT_TVALID,
  output logic                  AXIS_OUT_TLAST,
  input  logic                  AXIS_OUT_TREADY,
  output logic [CNT_W-1:0]      pkt_count
`ifdef AXIS_PACKETIZER_PAD_COUNT_EN
  ,
  output logic [CNT_W-1:0]      pad_count,
  output logic                  padding
`endif
);

  localparam logic [BEAT_IDX_W-1:0] LastIdx = BEAT_IDX_W'(PACKET_BEATS - 1);
  localparam logic [IDLE_CNT_W-1:0] IdleMax = IDLE_CNT_W'(TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [BEAT_IDX_W-1:0]   beat_idx_q, beat_idx_d;
  logic [IDLE_CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0]        pkt_count_q, pkt_count_d;

  logic                    slot_free;
  logic                    in_accept;
  logic                    load;
  logic                    beat_last;
  logic                    out_hs;
  logic [DATA_WIDTH-1:0]   load_data;

  // Held low through reset so nothing is taken while the slice is being cleared.
  assign AXIS_IN_TREADY = resetn && slot_free && (state_q != StPad);
  assign in_accept      = AXIS_IN_TVALID && AXIS_IN_TREADY;
  assign load           = in_accept || (slot_free && (state_q == StPad));
  assign beat_last      = (beat_idx_q == LastIdx);
  assign load_data      = (state_q == StPad) ? '0 : AXIS_IN_TDATA;
  assign out_hs         = AXIS_OUT_TVALID && AXIS_OUT_TREADY;

  axis_out_reg #(
    .DataWidth (DATA_WIDTH)
  ) u_out_reg (
    .clk         (clk),
    .resetn      (resetn),
    .load_i      (load),
    .data_i      (load_data),
    .last_i      (beat_last),
    .ready_i     (AXIS_OUT_TREADY),
    .valid_o     (AXIS_OUT_TVALID),
    .data_o      (AXIS_OUT_TDATA),
    .last_o      (AXIS_OUT_TLAST),
    .slot_free_o (slot_free)
  );

  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    beat_idx_d  = beat_idx_q;
    pkt_count_d = pkt_count_q;

    if (load) begin
      beat_idx_d = beat_last ? '0 : beat_idx_q + 1'b1;
    end
    if (out_hs && AXIS_OUT_TLAST) begin
      pkt_count_d = pkt_count_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (in_accept) begin
          state_d = beat_last ? StIdle : StFill;
        end
      end
      StFill: begin
        // Any valid, even one stalled by backpressure, restarts the idle window.
        if (in_accept && beat_last) begin
          state_d    = StIdle;
          idle_cnt_d = '0;
        end else if (AXIS_IN_TVALID) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IdleMax) begin
          state_d = StPad;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      StPad: begin
        if (load && beat_last) begin
          state_d    = StIdle;
          idle_cnt_d = '0;
        end
      end
      default: begin
        state_d    = StIdle;
        idle_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      beat_idx_q  <= '0;
      idle_cnt_q  <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_idx_q  <= beat_idx_d;
      idle_cnt_q  <= idle_cnt_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign pkt_count = pkt_count_q;

`ifdef AXIS_PACKETIZER_PAD_COUNT_EN
  // Tags the beat held in the output slice as a pad so it is counted at handoff.
  logic             out_pad_q, out_pad_d;
  logic [CNT_W-1:0] pad_count_q, pad_count_d;

  always_comb begin
    out_pad_d   = load ? (state_q == StPad) : out_pad_q;
    pad_count_d = pad_count_q;
    if (out_hs && out_pad_q) begin
      pad_count_d = pad_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_pad_q   <= 1'b0;
      pad_count_q <= '0;
    end else begin
      out_pad_q   <= out_pad_d;
      pad_count_q <= pad_count_d;
    end
  end

  assign pad_count = pad_count_q;
  assign padding   = (state_q == StPad);
`endif

endmodule

// File: doc/axis_packetizer.md
Name: axis_packetizer

Overview:
- Sits directly downstream of the 2:1 AXIS input switch and consumes its merged, TLAST-less 512-bit stream.
- Groups beats into fixed-length packets of PACKET_BEATS and asserts TLAST on the final beat.
- If the stream goes idle mid-packet, completes the packet with zero-filled pad beats so every packet downstream has exactly PACKET_BEATS beats.
- Output is registered (one register slice) for timing closure into the downstream DMA/PCIe path.

Parameters:
- DATA_WIDTH, 512, width of TDATA on both sides.
- PACKET_BEATS, 64, beats per packet; legal range 2..65535.
- TIMEOUT, 128, consecutive input-idle cycles inside an open packet before padding starts; legal range 1..65535.

Ports:
- clk  input  1  clock
- resetn  input  1  reset, synchronous, active-low
- AXIS_IN_TDATA  input  DATA_WIDTH  input data from switch
- AXIS_IN_TVALID  input  1  input valid
- AXIS_IN_TREADY  output  1  input ready
- AXIS_OUT_TDATA  output  DATA_WIDTH  packetized data
- AXIS_OUT_TVALID  output  1  output valid
- AXIS_OUT_TLAST  output  1  last beat of packet
- AXIS_OUT_TREADY  input  1  downstream ready
- pkt_count  output  32  completed packets (TLAST handshakes), wraps at 2^32

Behaviour:
- Reset values:
  - AXIS_OUT_TVALID=0, AXIS_OUT_TLAST=0, AXIS_OUT_TDATA=0, pkt_count=0.
  - beat_idx=0, idle_cnt=0, state=IDLE.
  - AXIS_IN_TREADY=0 while resetn=0.
- Output register:
  - slot_free = !AXIS_OUT_TVALID || AXIS_OUT_TREADY.
  - When slot_free, a beat is loaded (input beat or pad beat). Otherwise the register holds TDATA, TLAST and TVALID stable.
  - Latency: an accepted input beat appears on the output the next cycle.
  - No bubbles under continuous valid/ready.
- Ready:
  - AXIS_IN_TREADY = slot_free && state != PAD.
  - This is a combinational path from AXIS_OUT_TREADY.
- beat_idx (16 bit):
  - Increments on each beat loaded into the output register.
  - The loaded beat has TLAST = (beat_idx == PACKET_BEATS-1); beat_idx then wraps to 0.
- FSM states:
  - IDLE (no open packet):
    - No timeout counting.
    - Input accept -> FILL; if PACKET_BEATS==1 were legal it would stay, but the minimum legal value is 2.
  - FILL (partial packet open):
    - idle_cnt (16 bit) increments each cycle AXIS_IN_TVALID=0. It clears on any cycle AXIS_IN_TVALID=1, even if stalled by backpressure.
    - Accepting the TLAST beat -> IDLE, idle_cnt cleared.
    - idle_cnt == TIMEOUT-1 while TVALID=0 -> PAD.
  - PAD:
    - Input blocked.
    - Each cycle slot_free is true, loads a beat with TDATA=0 and advances beat_idx.
    - Loading the TLAST pad beat -> IDLE, idle_cnt cleared.
    - A pad beat waiting under backpressure is held like any other beat.
- Simultaneous events:
  - TVALID=1 in the same cycle idle_cnt would expire: the data wins, idle_cnt clears, no padding.
  - Input arriving during PAD: stalled until PAD completes. That data starts the next packet.
- pkt_count increments on the AXIS_OUT_TVALID && AXIS_OUT_TREADY && AXIS_OUT_TLAST handshake, not on load.
- Reset mid-operation: the partial packet and any held output beat are discarded. No TLAST is emitted for the truncated packet.

Optional Feature:
- Macro AXIS_PACKETIZER_PAD_COUNT_EN.
- When defined:
  - Adds output pad_count [31:0]: the number of pad beats handed off downstream.
  - Counts on handshake of beats loaded in PAD; reset 0; wraps.
  - Also adds output padding (1 bit), high while state==PAD.
- When undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Package axis_packetizer_pkg:
  - State enum {IDLE, FILL, PAD}.
  - BEAT_IDX_W=16, IDLE_CNT_W=16, CNT_W=32.
- Sub-module axis_out_reg: a single-stage AXIS register slice with TDATA/TLAST/TVALID, load-enable and slot_free output. Reusable elsewhere downstream of the switch.

Test Plan:
- PACKET_BEATS=4, continuous input D0..D7, out ready=1:
  - D0..D7 appear 1 cycle late, TLAST on D3 and D7, no bubbles.
  - pkt_count=2.
- Input 2 beats then idle, TIMEOUT=8:
  - After 8 idle cycles, 2 zero beats follow; TLAST on the 2nd pad.
  - pkt_count=1; pad_count=2 with macro.
- Input idles 7 cycles, then TVALID on the 8th (the expiry cycle):
  - Beat accepted, no pad beats emitted.
- Out TREADY held 0 for 10 cycles during a packet:
  - TDATA/TLAST stable, in TREADY=0, idle_cnt not incremented while input TVALID=1.
  - Resume gives no lost or duplicated beats.
- New input asserted during PAD:
  - in TREADY=0 until the TLAST pad beat is loaded.
  - The new data becomes beat 0 of the next packet.
- resetn=0 for 1 cycle after beat 2 of a packet:
  - Out TVALID=0, pkt_count=0.
  - The next input beat is beat 0 of a fresh packet.
